ws2812_rx: RTL and testbench
============================

WS2812_RX -- requirements
Module: ws2812_rx

Interface
REQ-001 SHALL have parameter F_CLK, default 12_000_000: clock frequency in Hz.
REQ-002 SHALL have parameter T1_THRESH_NS, default 600: minimum high time for a '1' bit.
REQ-003 SHALL have parameter T_GLITCH_NS, default 150: high pulses of this length or shorter are glitches.
REQ-004 SHALL have parameter T_HIGH_MAX_NS, default 5_000: high pulses of this length or longer are errors.
REQ-005 SHALL have parameter T_RESET_NS, default 50_000: low time that ends a frame.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic SHALL be rising-edge clocked.
REQ-007 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-008 SHALL have port din, input, 1 bit: asynchronous WS2812 serial line.
REQ-009 SHALL have port pixel_data, output, 24 bits: last decoded pixel, GRB order, [23:16]=G, [15:8]=R, [7:0]=B.
REQ-010 SHALL have port pixel_valid, output, 1 bit: one-cycle strobe; pixel_data is new.
REQ-011 SHALL have port frame_end, output, 1 bit: one-cycle strobe on the latch/reset gap.
REQ-012 SHALL have port frame_pixels, output, 16 bits: pixel count of the frame just ended, valid from the frame_end cycle onward.
REQ-013 SHALL have port err, output, 1 bit: one-cycle strobe on a protocol error.

Function
REQ-014 SHALL compute cycle constants as floor(F_CLK*ns/1e9): at 12 MHz THRESH=7, GLITCH=1, HIGH_MAX=60, RESET=600.
REQ-015 SHALL pass din through a 2-flop synchronizer before any use; edge detection SHALL use the synchronized signal and one further delayed copy.
REQ-016 SHALL implement states IDLE, HIGH, LOW, WAIT_GAP.
REQ-017 IDLE: on a synchronized rising edge SHALL go to HIGH with high_cnt=1.
REQ-018 HIGH: SHALL increment high_cnt each high cycle; on a falling edge SHALL classify the bit as 1 if high_cnt>=THRESH, 0 if GLITCH<high_cnt<THRESH, glitch if high_cnt<=GLITCH, then go to LOW with low_cnt=0.
REQ-019 HIGH: when high_cnt reaches HIGH_MAX SHALL pulse err, discard the partial pixel and go to WAIT_GAP.
REQ-020 A glitch SHALL pulse err, discard the partial pixel and go to WAIT_GAP.
REQ-021 Bits SHALL shift in MSB first; after the 24th valid bit, pixel_data SHALL update and pixel_valid SHALL pulse exactly 3 clk cycles after the din falling edge ending that bit; the bit counter SHALL then return to 0.
REQ-022 LOW: a rising edge SHALL go to HIGH; when low_cnt reaches RESET SHALL go to IDLE.
REQ-023 On reaching RESET in LOW with bit count 0 and at least one pixel since the last frame_end: SHALL pulse frame_end, latch frame_pixels, and clear the pixel counter.
REQ-024 On reaching RESET in LOW with bit count nonzero: SHALL pulse err, discard the bits, and latch frame_pixels and pulse frame_end only if at least one pixel completed.
REQ-025 WAIT_GAP: SHALL ignore data until din has been low for RESET consecutive cycles, then go to IDLE; frame_end SHALL follow REQ-023 for pixels completed before the error.
REQ-026 The pixel counter SHALL saturate at 65535; low_cnt and high_cnt SHALL saturate at their terminal values.
REQ-027 A gap of RESET cycles with no pixels received SHALL produce no frame_end.
REQ-028 pixel_valid and frame_end SHALL each be able to assert in the same cycle as err; pixel_valid and frame_end SHALL never assert in the same cycle.

Reset
REQ-029 rst_n low at a clk edge SHALL set state IDLE, sync flops 0, all counters 0, pixel_data 0, frame_pixels 0, and pixel_valid, frame_end and err 0.
REQ-030 Reset mid-pixel or mid-frame SHALL discard all partial state; no strobes SHALL assert during or on the cycle after reset release.

Verification
REQ-031 At 12 MHz, send 24 bits 0xFF0000 (1=10 high/5 low, 0=5 high/10 low cycles) -> pixel_data=0xFF0000 and one pixel_valid, 3 cycles after the last falling edge.
REQ-032 Send 3 pixels 0x123456, 0xABCDEF, 0x000001, then hold 600 low cycles -> three pixel_valid in order, then frame_end with frame_pixels=3.
REQ-033 Send 12 bits, then hold low 600 cycles -> err pulse; no pixel_valid; no frame_end.
REQ-034 Send a 1-cycle high pulse mid-pixel -> err; subsequent bits ignored until 600 low cycles elapse; the next full pixel decodes correctly.
REQ-035 Hold din high 60 cycles -> err at cycle 60; state WAIT_GAP.
REQ-036 Assert rst_n=0 after 10 bits of a pixel, release, send a full pixel 0x00FF00 -> pixel_data=0x00FF00, one pixel_valid, no err.

Source files
------------

// File: rtl/ws2812_rx.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | ws2812_rx : WS2812 serial line decoder producing GRB pixels and frame info |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module ws2812_rx #(
    parameter int F_CLK         = 12_000_000,
    parameter int T1_THRESH_NS  = 600,
    parameter int T_GLITCH_NS   = 150,
    parameter int T_HIGH_MAX_NS = 5_000,
    parameter int T_RESET_NS    = 50_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din,
    output logic [23:0] pixel_data,
    output logic        pixel_valid,
    output logic        frame_end,
    output logic [15:0] frame_pixels,
    output logic        err
);

    localparam int c_thresh   = int'((64'(F_CLK) * 64'(T1_THRESH_NS))  / 64'd1_000_000_000);
    localparam int c_glitch   = int'((64'(F_CLK) * 64'(T_GLITCH_NS))   / 64'd1_000_000_000);
    localparam int c_high_max = int'((64'(F_CLK) * 64'(T_HIGH_MAX_NS)) / 64'd1_000_000_000);
    localparam int c_reset    = int'((64'(F_CLK) * 64'(T_RESET_NS))    / 64'd1_000_000_000);
    localparam int c_hw       = $clog2(c_high_max + 1);
    localparam int c_lw       = $clog2(c_reset + 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_HIGH     = 2'd1;
    localparam logic [1:0] S_LOW      = 2'd2;
    localparam logic [1:0] S_WAIT_GAP = 2'd3;

    logic            sync1_q, sync2_q, prev_q;
    logic [1:0]      state_q, state_d;
    logic [c_hw-1:0] high_q, high_d;
    logic [c_lw-1:0] low_q, low_d;
    logic [4:0]      bit_q, bit_d;
    logic [23:0]     shift_q, shift_d;
    logic [15:0]     pix_q, pix_d;
    logic [23:0]     pdata_q, pdata_d;
    logic [15:0]     fpix_q, fpix_d;
    logic            pv_q, pv_d;
    logic            fe_q, fe_d;
    logic            err_q, err_d;

    logic            w_rise, w_fall, w_bit, w_gap_done;
    logic [23:0]     w_shift;

    assign w_rise  = sync2_q & ~prev_q;
    assign w_fall  = ~sync2_q & prev_q;
    assign w_bit   = (int'(high_q) >= c_thresh);
    assign w_shift = {shift_q[22:0], w_bit};

    // State register and all datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            state_q <= S_IDLE;
            high_q  <= '0;
            low_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            pix_q   <= '0;
            pdata_q <= '0;
            fpix_q  <= '0;
            pv_q    <= 1'b0;
            fe_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            high_q  <= high_d;
            low_q   <= low_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            pix_q   <= pix_d;
            pdata_q <= pdata_d;
            fpix_q  <= fpix_d;
            pv_q    <= pv_d;
            fe_q    <= fe_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        high_d     = high_q;
        low_d      = low_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        pix_d      = pix_q;
        pdata_d    = pdata_q;
        fpix_d     = fpix_q;
        pv_d       = 1'b0;
        fe_d       = 1'b0;
        err_d      = 1'b0;
        w_gap_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_rise) begin
                    state_d = S_HIGH;
                    high_d  = c_hw'(1);
                end
            end
            S_HIGH: begin
                if (w_fall) begin
                    low_d = '0;
                    if (int'(high_q) <= c_glitch) begin
                        err_d   = 1'b1;
                        bit_d   = '0;
                        state_d = S_WAIT_GAP;
                    end else begin
                        state_d = S_LOW;
                        shift_d = w_shift;
                        if (bit_q == 5'd23) begin
                            pdata_d = w_shift;
                            pv_d    = 1'b1;
                            bit_d   = '0;
                            pix_d   = (pix_q == 16'hFFFF) ? pix_q : pix_q + 16'd1;
                        end else begin
                            bit_d = bit_q + 5'd1;
                        end
                    end
                end else if (int'(high_q) >= c_high_max - 1) begin
                    // Line stuck high: this cycle is the HIGH_MAX-th high cycle.
                    high_d  = c_hw'(c_high_max);
                    err_d   = 1'b1;
                    bit_d   = '0;
                    low_d   = '0;
                    state_d = S_WAIT_GAP;
                end else begin
                    high_d = high_q + 1'b1;
                end
            end
            S_LOW: begin
                if (w_rise) begin
                    state_d = S_HIGH;
                    high_d  = c_hw'(1);
                end else if (int'(low_q) >= c_reset - 1) begin
                    low_d      = c_lw'(c_reset);
                    state_d    = S_IDLE;
                    w_gap_done = 1'b1;
                    err_d      = (bit_q != 5'd0);
                    bit_d      = '0;
                end else begin
                    low_d = low_q + 1'b1;
                end
            end
            S_WAIT_GAP: begin
                if (sync2_q) begin
                    low_d = '0;
                end else if (int'(low_q) >= c_reset - 1) begin
                    low_d      = c_lw'(c_reset);
                    state_d    = S_IDLE;
                    w_gap_done = 1'b1;
                end else begin
                    low_d = low_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A gap closes the frame only if it actually carried pixels.
        if (w_gap_done && (pix_q != 16'd0)) begin
            fe_d   = 1'b1;
            fpix_d = pix_q;
            pix_d  = '0;
        end
    end

    // Output logic.
    always_comb begin
        pixel_data   = pdata_q;
        pixel_valid  = pv_q;
        frame_end    = fe_q;
        frame_pixels = fpix_q;
        err          = err_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_ws2812_rx.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_ws2812_rx : pulse-level reference model bench for ws2812_rx             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_ws2812_rx;

    localparam int C_THRESH   = 7;
    localparam int C_GLITCH   = 1;
    localparam int C_HIGH_MAX = 60;
    localparam int C_GAP      = 700;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din = 1'b0;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic        frame_end;
    logic [15:0] frame_pixels;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int act_err = 0;
    int exp_err = 0;
    int last_err_cyc = 0;
    int last_rise = 0;

    logic [23:0] exp_pix[$];
    int          exp_cyc[$];
    int          exp_fe[$];

    // Reference model state: bits collected, pixels in frame, error-wait flag.
    int          m_bits = 0;
    logic [23:0] m_sh = '0;
    int          m_pix = 0;
    bit          m_wait = 1'b0;

    ws2812_rx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .din          (din),
        .pixel_data   (pixel_data),
        .pixel_valid  (pixel_valid),
        .frame_end    (frame_end),
        .frame_pixels (frame_pixels),
        .err          (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (pixel_valid) begin
            check_eq("pv_fe_excl", 32'(frame_end), 32'd0);
            check_eq("pv_expected", 32'(exp_pix.size() > 0), 32'd1);
            if (exp_pix.size() > 0) begin
                check_eq("pv_data", 32'(pixel_data), 32'(exp_pix.pop_front()));
                check_eq("pv_cycle", cyc, exp_cyc.pop_front());
            end
        end
        if (frame_end) begin
            check_eq("fe_expected", 32'(exp_fe.size() > 0), 32'd1);
            if (exp_fe.size() > 0)
                check_eq("fe_pixels", 32'(frame_pixels), exp_fe.pop_front());
        end
        if (err) begin
            act_err++;
            last_err_cyc = cyc;
        end
    end

    // Model: classify one whole high pulse by its length.
    function automatic void model_pulse(input int hi, input int fall);
        if (m_wait) return;
        if (hi >= C_HIGH_MAX || hi <= C_GLITCH) begin
            exp_err++;
            m_bits = 0;
            m_wait = 1'b1;
            return;
        end
        m_sh = {m_sh[22:0], (hi >= C_THRESH)};
        m_bits++;
        if (m_bits == 24) begin
            exp_pix.push_back(m_sh);
            exp_cyc.push_back(fall + 3);
            m_bits = 0;
            if (m_pix < 65535) m_pix++;
        end
    endfunction

    function automatic void model_gap();
        if (!m_wait && m_bits != 0) exp_err++;
        if (m_pix > 0) exp_fe.push_back(m_pix);
        m_pix  = 0;
        m_bits = 0;
        m_wait = 1'b0;
    endfunction

    // Called at a negedge; returns at a negedge with din low.
    task automatic send_pulse(input int hi, input int lo);
        din = 1'b1;
        last_rise = cyc;
        repeat (hi) @(negedge clk);
        din = 1'b0;
        model_pulse(hi, cyc);
        repeat (lo) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input bit fixed);
        int hi, lo;
        if (fixed) begin
            hi = b ? 10 : 5;
            lo = b ? 5 : 10;
        end else begin
            if (b) hi = ($urandom_range(0, 15) == 0) ? 59 : int'($urandom_range(7, 15));
            else   hi = int'($urandom_range(2, 6));
            lo = int'($urandom_range(1, 12));
        end
        send_pulse(hi, lo);
    endtask

    task automatic send_pixel(input logic [23:0] d, input bit fixed);
        for (int b = 23; b >= 0; b--) send_bit(d[b], fixed);
    endtask

    task automatic send_gap();
        model_gap();
        repeat (C_GAP) @(negedge clk);
    endtask

    task automatic check_frame();
        check_eq("pix_pending", 32'(exp_pix.size()), 32'd0);
        check_eq("fe_pending", 32'(exp_fe.size()), 32'd0);
        check_eq("err_count", act_err, exp_err);
    endtask

    initial begin
        logic [23:0] d;
        repeat (3) @(negedge clk);
        check_eq("rst_pixel_data", 32'(pixel_data), 32'd0);
        check_eq("rst_frame_pixels", 32'(frame_pixels), 32'd0);
        check_eq("rst_pv", 32'(pixel_valid), 32'd0);
        check_eq("rst_fe", 32'(frame_end), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single pixel with nominal timing.
        send_pixel(24'hFF0000, 1'b1);
        send_gap();
        check_frame();
        check_eq("single_data", 32'(pixel_data), 32'h00FF0000);

        // Three pixels in one frame.
        send_pixel(24'h123456, 1'b1);
        send_pixel(24'hABCDEF, 1'b1);
        send_pixel(24'h000001, 1'b1);
        send_gap();
        check_frame();
        check_eq("three_fp", 32'(frame_pixels), 32'd3);

        // Half a pixel then a gap: error, no pixel, no frame.
        d = 24'hA5A5A5;
        for (int b = 23; b >= 12; b--) send_bit(d[b], 1'b1);
        send_gap();
        check_frame();

        // Glitch mid-pixel, remaining bits ignored, then a clean pixel.
        d = 24'h3C3C3C;
        for (int b = 23; b >= 16; b--) send_bit(d[b], 1'b1);
        send_pulse(1, 10);
        for (int b = 15; b >= 0; b--) send_bit(d[b], 1'b1);
        send_gap();
        send_pixel(24'h5AA55A, 1'b1);
        send_gap();
        check_frame();

        // Line held high for exactly HIGH_MAX cycles.
        send_pulse(C_HIGH_MAX, 10);
        check_eq("hmax_err_cyc", last_err_cyc, last_rise + 2 + C_HIGH_MAX);
        send_pixel(24'h0F0F0F, 1'b1);
        send_gap();
        check_frame();

        // Reset partway through a pixel.
        d = 24'h00FF00;
        for (int b = 23; b >= 14; b--) send_bit(d[b], 1'b1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("mid_rst_pixel_data", 32'(pixel_data), 32'd0);
        check_eq("mid_rst_frame_pixels", 32'(frame_pixels), 32'd0);
        check_eq("mid_rst_strobes", {29'd0, pixel_valid, frame_end, err}, 32'd0);
        m_bits = 0;
        m_pix  = 0;
        m_wait = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_strobes", {29'd0, pixel_valid, frame_end, err}, 32'd0);
        send_pixel(24'h00FF00, 1'b1);
        send_gap();
        check_frame();
        check_eq("rst_recover_data", 32'(pixel_data), 32'h0000FF00);

        // Randomized frames with occasional injected faults.
        for (int f = 0; f < 12; f++) begin
            int np, fault, fpix, fbit;
            bit stop;
            np    = int'($urandom_range(1, 3));
            fault = int'($urandom_range(0, 5));
            fpix  = int'($urandom_range(0, np - 1));
            fbit  = int'($urandom_range(0, 23));
            stop  = 1'b0;
            for (int p = 0; p < np && !stop; p++) begin
                d = 24'($urandom);
                for (int b = 23; b >= 0 && !stop; b--) begin
                    if (fault < 3 && p == fpix && b == fbit) begin
                        case (fault)
                            0:       send_pulse(1, int'($urandom_range(1, 12)));
                            1:       send_pulse(int'($urandom_range(60, 66)), int'($urandom_range(1, 12)));
                            default: stop = 1'b1;
                        endcase
                    end
                    if (!stop) send_bit(d[b], 1'b0);
                end
            end
            send_gap();
            check_frame();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
